issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 8, meaning the number of reservation-station entries (a power of two, at least 2).
REQ-002 The module SHALL have parameter PKT_W, default 64, meaning the width of the dispatch packet in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port flush, input, 1 bit: discard all entries.
REQ-006 The module SHALL have port disp_valid, input, 1 bit: dispatch request.
REQ-007 The module SHALL have port disp_ready, output, 1 bit: a free entry exists.
REQ-008 The module SHALL have port disp_dep_mask, input, ENTRIES bits: producer entries the new instruction waits on.
REQ-009 The module SHALL have port disp_pkt, input, PKT_W bits: payload to store.
REQ-010 The module SHALL have port disp_idx, output, clog2(ENTRIES) bits: entry allocated on the current dispatch.
REQ-011 The module SHALL have port fire_valid, output, 1 bit: a selected entry is offered to register read.
REQ-012 The module SHALL have port fire_ready, input, 1 bit: register read accepts the offered entry.
REQ-013 The module SHALL have port fire_pkt, output, PKT_W bits: payload of the offered entry.
REQ-014 The module SHALL have port fire_idx, output, clog2(ENTRIES) bits: index of the offered entry.
REQ-015 The module SHALL have port local_ready_mask, output, ENTRIES bits: one-hot wakeup broadcast for the entry this queue issued.
REQ-016 The module SHALL have port global_ready_mask, input, ENTRIES bits: the OR of all pipes' wakeups, which clears dependencies.
REQ-017 The module SHALL have port occupancy, output, clog2(ENTRIES+1) bits: the count of valid entries.

Function
REQ-018 Each entry SHALL hold valid, a dependency row of ENTRIES bits, and a payload; an entry SHALL be ready when valid and its row is all zero.
REQ-019 disp_ready SHALL equal (occupancy != ENTRIES) and not flush; disp_idx SHALL be the lowest-index invalid entry, computed combinationally.
REQ-020 On disp_valid && disp_ready the entry SHALL be written with valid=1, payload=disp_pkt, and row=disp_dep_mask & ~global_ready_mask with the self bit forced to 0.
REQ-021 disp_valid while disp_ready=0 SHALL be ignored with no state change.
REQ-022 Each cycle, every valid row SHALL clear the bits set in global_ready_mask.
REQ-023 A newly dispatched entry SHALL NOT be offered for fire before the cycle after it is written.
REQ-024 fire_valid SHALL be asserted when any entry is ready; fire_idx/fire_pkt SHALL come from the selected entry, combinationally.
REQ-025 Selection SHALL be per REQ-033/034.
REQ-026 The selection SHALL be held stable while fire_valid && !fire_ready, unless flush.
REQ-027 On fire_valid && fire_ready the entry SHALL be invalidated at the clock edge.
REQ-028 On fire_valid && fire_ready, local_ready_mask SHALL be the registered one-hot of fire_idx in the following cycle, and zero in every other cycle.
REQ-029 An entry freed by fire SHALL be allocatable from the next cycle.
REQ-030 Dispatch and fire in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-031 On flush, all valid bits SHALL clear at the next edge, local_ready_mask SHALL be 0 in the next cycle, and fire_valid SHALL be forced to 0 during the flush cycle.

Reset
REQ-032 While rst=1 at an edge, all valid bits, rows, payloads and local_ready_mask SHALL clear; after reset, occupancy=0, disp_ready=1, fire_valid=0, and fire_pkt=0.

Configuration
REQ-033 With ISSUE_QUEUE_AGE_SELECT_EN defined, an ENTRIES x ENTRIES age matrix SHALL be kept, set at dispatch so the new entry is younger than all valid entries, and the oldest ready entry SHALL be selected.
REQ-034 Without ISSUE_QUEUE_AGE_SELECT_EN, no age matrix SHALL exist and the lowest-index ready entry SHALL be selected.

Verification
REQ-035 The bench SHALL cover: after reset, dispatch pkt=0xA5 with dep=0 -> next cycle fire_valid=1, fire_idx=0, fire_pkt=0xA5; with fire_ready=1, local_ready_mask=0x01 the following cycle.
REQ-036 The bench SHALL cover: dispatch entry0, then entry1 with dep=0x01 and the bench looping local into global -> entry1 fires exactly 1 cycle after the entry0 wakeup.
REQ-037 The bench SHALL cover: fill 8 entries with no deps and fire_ready=0 -> disp_ready=0 and occupancy=8; one extra dispatch is ignored; fire_idx holds stable while stalled.
REQ-038 The bench SHALL cover: with the age macro on, dispatch into idx2, free idx0, dispatch into idx0, both ready -> idx2 fires first; with the macro off -> idx0 fires first.
REQ-039 The bench SHALL cover: dispatch with dep bit3 set while global_ready_mask=0x08 in the same cycle -> the entry is ready next cycle.
REQ-040 The bench SHALL cover: flush with 5 valid entries and fire pending -> fire_valid=0 in that cycle, occupancy=0 next cycle, and local_ready_mask=0.

Source files
------------

// File: rtl/issue_queue_if.sv
// issue_queue_if: dispatch, fire, wakeup and flush signals of one issue queue.
// slave is the queue side; master is the surrounding pipeline side.
interface issue_queue_if #(
  parameter int ENTRIES = 8,
  parameter int PKT_W   = 64
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES + 1);

  logic               flush;
  logic               disp_valid;
  logic               disp_ready;
  logic [ENTRIES-1:0] disp_dep_mask;
  logic [PKT_W-1:0]   disp_pkt;
  logic [IDX_W-1:0]   disp_idx;
  logic               fire_valid;
  logic               fire_ready;
  logic [PKT_W-1:0]   fire_pkt;
  logic [IDX_W-1:0]   fire_idx;
  logic [ENTRIES-1:0] local_ready_mask;
  logic [ENTRIES-1:0] global_ready_mask;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output flush, disp_valid, disp_dep_mask, disp_pkt, fire_ready, global_ready_mask,
    input  disp_ready, disp_idx, fire_valid, fire_pkt, fire_idx, local_ready_mask, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_dep_mask, disp_pkt, fire_ready, global_ready_mask,
    output disp_ready, disp_idx, fire_valid, fire_pkt, fire_idx, local_ready_mask, occupancy
  );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: reservation-station issue queue with a dependency matrix.
// Each entry holds valid, a row of producer-entry dependencies and a payload.
// An entry is ready once valid with an all-zero row; one ready entry is
// offered per cycle, and an accepted fire broadcasts a one-hot wakeup.
// Build option ISSUE_QUEUE_AGE_SELECT_EN: keep an age matrix and pick the
// oldest ready entry; when undefined, pick the lowest-index ready entry.
module issue_queue #(
  parameter int ENTRIES = 8,
  parameter int PKT_W   = 64
) (
  input  logic         clk,
  input  logic         rst,
  issue_queue_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][ENTRIES-1:0] row_q, row_d;
  logic [ENTRIES-1:0][PKT_W-1:0]   pkt_q, pkt_d;
  logic [ENTRIES-1:0]              lrm_q, lrm_d;
  logic                            hold_q, hold_d;
  logic [IDX_W-1:0]                hold_idx_q, hold_idx_d;

  logic [ENTRIES-1:0] ready;
  logic [ENTRIES-1:0] cand;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   free_idx;
  logic [OCC_W-1:0]   occ;
  logic               fire_vld;
  logic               fire_go;
  logic               disp_rdy;
  logic               disp_go;

  // An entry is ready when it is valid and waits on no producer
  always_comb begin
    ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = valid_q[i] && (row_q[i] == '0);
    end
  end

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;

  // Candidates are ready entries that no other ready entry is older than
  always_comb begin
    cand = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cand[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (ready[j] && older_q[j][i]) cand[i] = 1'b0;
      end
    end
  end

  // A new entry is younger than everything: clear its row, set its column
  always_comb begin
    older_d = older_q;
    if (disp_go) begin
      older_d[free_idx] = '0;
      for (int j = 0; j < ENTRIES; j++) begin
        older_d[j][free_idx] = (j != int'(free_idx));
      end
    end
  end

  // Age matrix register
  always_ff @(posedge clk) begin
    if (rst) older_q <= '0;
    else     older_q <= older_d;
  end
`else
  // Without age tracking every ready entry is a candidate
  always_comb begin
    cand = ready;
  end
`endif

  // Lowest-index candidate for fire, lowest-index free slot for dispatch
  always_comb begin
    pick_idx = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (cand[i])     pick_idx = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Occupancy is the population count of the valid bits
  always_comb begin
    occ = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ = occ + OCC_W'(valid_q[i]);
    end
  end

  // Handshakes; a stalled offer keeps its index until accepted or flushed
  always_comb begin
    sel_idx  = hold_q ? hold_idx_q : pick_idx;
    fire_vld = (|ready) && !bus.flush;
    fire_go  = fire_vld && bus.fire_ready;
    disp_rdy = (occ != OCC_W'(ENTRIES)) && !bus.flush;
    disp_go  = bus.disp_valid && disp_rdy;
  end

  assign bus.disp_ready       = disp_rdy;
  assign bus.disp_idx         = free_idx;
  assign bus.fire_valid       = fire_vld;
  assign bus.fire_idx         = sel_idx;
  assign bus.fire_pkt         = fire_vld ? pkt_q[sel_idx] : '0;
  assign bus.local_ready_mask = lrm_q;
  assign bus.occupancy        = occ;

  // Entry update: wakeup clearing, fire invalidation, dispatch write, flush
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    row_d   = row_q;
    for (int i = 0; i < ENTRIES; i++) begin
      row_d[i] = row_q[i] & ~bus.global_ready_mask;
    end
    if (fire_go) valid_d[sel_idx] = 1'b0;
    if (disp_go) begin
      valid_d[free_idx] = 1'b1;
      pkt_d[free_idx]   = bus.disp_pkt;
      // Wakeups arriving this cycle are already applied; never wait on self
      row_d[free_idx]   = bus.disp_dep_mask & ~bus.global_ready_mask
                          & ~(ENTRIES'(1) << free_idx);
    end
    if (bus.flush) valid_d = '0;
    lrm_d      = fire_go ? (ENTRIES'(1) << sel_idx) : '0;
    hold_d     = fire_vld && !bus.fire_ready;
    hold_idx_d = sel_idx;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      row_q      <= '0;
      pkt_q      <= '0;
      lrm_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      valid_q    <= valid_d;
      row_q      <= row_d;
      pkt_q      <= pkt_d;
      lrm_q      <= lrm_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: table-driven vectors, directed corner sequences and a
// randomized run checked against a behavioural model of the issue queue.
module tb_issue_queue;
  localparam int N  = 8;
  localparam int PW = 64;

`ifdef ISSUE_QUEUE_AGE_SELECT_EN
  localparam int AGE_FIRST  = 2;
  localparam int AGE_SECOND = 0;
`else
  localparam int AGE_FIRST  = 0;
  localparam int AGE_SECOND = 2;
`endif

  logic clk = 1'b0;
  logic rst;

  issue_queue_if #(.ENTRIES(N), .PKT_W(PW)) bus ();
  issue_queue #(.ENTRIES(N), .PKT_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: valid flags, pending-producer sets, payloads and a
  // dispatch sequence number per entry (smaller number = older).
  bit              m_v    [N];
  logic [N-1:0]    m_dep  [N];
  logic [PW-1:0]   m_pkt  [N];
  int unsigned     m_seq  [N];
  int unsigned     seq_ctr;
  bit              m_hold;
  int              m_hold_idx;
  logic [N-1:0]    m_lrm;
  bit              e_dr;
  int              e_didx;
  bit              e_fv;
  int              e_fidx;
  logic [PW-1:0]   e_fpkt;
  int              e_occ;

  typedef struct {
    bit          rst;
    bit          dv;
    logic [N-1:0] dep;
    logic [PW-1:0] pkt;
    bit          fr;
    logic [N-1:0] gm;
    bit          dr;
    int          didx;
    bit          fv;
    int          fidx;
    logic [PW-1:0] fpkt;
    logic [N-1:0] lrm;
    int          occ;
    bit          chk;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic vec_t mk(bit r, bit dv, int dep, logic [PW-1:0] pkt, bit fr, int gm,
                              bit dr, int didx, bit fv, int fidx, logic [PW-1:0] fpkt,
                              int lrm, int occ, bit c);
    vec_t v;
    v.rst = r;  v.dv = dv; v.dep = N'(dep); v.pkt = pkt; v.fr = fr; v.gm = N'(gm);
    v.dr = dr;  v.didx = didx; v.fv = fv; v.fidx = fidx; v.fpkt = fpkt;
    v.lrm = N'(lrm); v.occ = occ; v.chk = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Model outputs for the current state and the inputs now on the bus
  task automatic model_eval();
    int  occ_c;
    int  best;
    bit  found;
    occ_c  = 0;
    found  = 0;
    e_didx = 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) occ_c++;
      else if (!found) begin
        e_didx = i;
        found  = 1;
      end
    end
    e_occ = occ_c;
    e_dr  = (occ_c != N) && !bus.flush;
    best  = -1;
    if (m_hold) best = m_hold_idx;
    else begin
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && m_dep[i] == '0) begin
`ifdef ISSUE_QUEUE_AGE_SELECT_EN
          if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
          if (best < 0) best = i;
`endif
        end
      end
    end
    e_fv   = (best >= 0) && !bus.flush;
    e_fidx = (best >= 0) ? best : 0;
    e_fpkt = e_fv ? m_pkt[best] : '0;
  endtask

  // Model state change at a rising edge given the inputs now on the bus
  task automatic model_edge();
    bit fgo;
    bit dgo;
    model_eval();
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] = 0; m_dep[i] = '0; m_pkt[i] = '0; m_seq[i] = 0;
      end
      seq_ctr = 0; m_hold = 0; m_hold_idx = 0; m_lrm = '0;
    end else begin
      fgo = e_fv && bus.fire_ready;
      dgo = bus.disp_valid && e_dr;
      for (int i = 0; i < N; i++) m_dep[i] = m_dep[i] & ~bus.global_ready_mask;
      if (fgo) m_v[e_fidx] = 0;
      if (dgo) begin
        m_v[e_didx]          = 1;
        m_pkt[e_didx]        = bus.disp_pkt;
        m_dep[e_didx]        = bus.disp_dep_mask & ~bus.global_ready_mask;
        m_dep[e_didx][e_didx] = 1'b0;
        m_seq[e_didx]        = seq_ctr;
        seq_ctr++;
      end
      m_lrm = '0;
      if (fgo) m_lrm[e_fidx] = 1'b1;
      m_hold     = e_fv && !bus.fire_ready;
      m_hold_idx = e_fidx;
      if (bus.flush) for (int i = 0; i < N; i++) m_v[i] = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit f, bit dv, int dep, logic [PW-1:0] pkt, bit fr, int gm);
    bus.flush             = f;
    bus.disp_valid        = dv;
    bus.disp_dep_mask     = N'(dep);
    bus.disp_pkt          = pkt;
    bus.fire_ready        = fr;
    bus.global_ready_mask = N'(gm);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_model();
    model_eval();
    chk("rnd_disp_ready", 64'(bus.disp_ready), 64'(e_dr));
    chk("rnd_disp_idx", 64'(bus.disp_idx), 64'(e_didx));
    chk("rnd_fire_valid", 64'(bus.fire_valid), 64'(e_fv));
    if (e_fv) chk("rnd_fire_idx", 64'(bus.fire_idx), 64'(e_fidx));
    chk("rnd_fire_pkt", bus.fire_pkt, e_fpkt);
    chk("rnd_local_ready_mask", 64'(bus.local_ready_mask), 64'(m_lrm));
    chk("rnd_occupancy", 64'(bus.occupancy), 64'(e_occ));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int wake_cyc;
    int fire_cyc;
    int gm;

    //        rst dv dep   pkt      fr gm   | dr didx fv fidx fpkt    lrm  occ chk
    tbl[0]  = mk(1, 0, 'h00, 64'h0,  0, 'h00,  0, 0,  0, 0,  64'h0,  'h00, 0, 0);
    tbl[1]  = mk(0, 0, 'h00, 64'h0,  0, 'h00,  1, 0,  0, 0,  64'h0,  'h00, 0, 1);
    tbl[2]  = mk(0, 1, 'h00, 64'hA5, 0, 'h00,  1, 0,  0, 0,  64'h0,  'h00, 0, 1);
    tbl[3]  = mk(0, 0, 'h00, 64'h0,  1, 'h00,  1, 1,  1, 0,  64'hA5, 'h00, 1, 1);
    tbl[4]  = mk(0, 0, 'h00, 64'h0,  0, 'h00,  1, 0,  0, 0,  64'h0,  'h01, 0, 1);
    tbl[5]  = mk(0, 0, 'h00, 64'h0,  0, 'h00,  1, 0,  0, 0,  64'h0,  'h00, 0, 1);
    tbl[6]  = mk(0, 1, 'h08, 64'h39, 0, 'h08,  1, 0,  0, 0,  64'h0,  'h00, 0, 1);
    tbl[7]  = mk(0, 0, 'h00, 64'h0,  0, 'h00,  1, 1,  1, 0,  64'h39, 'h00, 1, 1);
    tbl[8]  = mk(0, 1, 'h01, 64'h77, 0, 'h00,  1, 1,  1, 0,  64'h39, 'h00, 1, 1);
    tbl[9]  = mk(0, 0, 'h00, 64'h0,  1, 'h00,  1, 2,  1, 0,  64'h39, 'h00, 2, 1);
    tbl[10] = mk(0, 0, 'h00, 64'h0,  1, 'h00,  1, 0,  0, 0,  64'h0,  'h01, 1, 1);
    tbl[11] = mk(0, 0, 'h00, 64'h0,  0, 'h01,  1, 0,  0, 0,  64'h0,  'h00, 1, 1);
    tbl[12] = mk(0, 0, 'h00, 64'h0,  1, 'h00,  1, 0,  1, 1,  64'h77, 'h00, 1, 1);
    tbl[13] = mk(0, 0, 'h00, 64'h0,  0, 'h00,  1, 0,  0, 0,  64'h0,  'h02, 0, 1);

    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0);

    // Vector table: reset state, basic dispatch/fire, same-cycle wakeup
    for (int k = 0; k < NV; k++) begin
      rst = tbl[k].rst;
      drive(0, tbl[k].dv, int'(tbl[k].dep), tbl[k].pkt, tbl[k].fr, int'(tbl[k].gm));
      if (tbl[k].chk) begin
        chk($sformatf("v%0d_disp_ready", k), 64'(bus.disp_ready), 64'(tbl[k].dr));
        chk($sformatf("v%0d_disp_idx", k), 64'(bus.disp_idx), 64'(tbl[k].didx));
        chk($sformatf("v%0d_fire_valid", k), 64'(bus.fire_valid), 64'(tbl[k].fv));
        if (tbl[k].fv) chk($sformatf("v%0d_fire_idx", k), 64'(bus.fire_idx), 64'(tbl[k].fidx));
        chk($sformatf("v%0d_fire_pkt", k), bus.fire_pkt, tbl[k].fpkt);
        chk($sformatf("v%0d_lrm", k), 64'(bus.local_ready_mask), 64'(tbl[k].lrm));
        chk($sformatf("v%0d_occupancy", k), 64'(bus.occupancy), 64'(tbl[k].occ));
      end
      tick();
    end
    rst = 1'b0;

    // Wakeup loopback: consumer fires exactly one cycle after producer wakeup
    do_reset();
    drive(0, 1, 'h00, 64'h100, 0, 0);
    tick();
    drive(0, 1, 'h01, 64'h101, 1, 0);
    chk("loop_producer_fire_idx", 64'(bus.fire_idx), 64'd0);
    tick();
    wake_cyc = -1;
    fire_cyc = -1;
    for (int c = 0; c < 12 && fire_cyc < 0; c++) begin
      drive(0, 0, 0, '0, 1, int'(bus.local_ready_mask));
      if (bus.local_ready_mask == N'(1) && wake_cyc < 0) wake_cyc = c;
      if (bus.fire_valid && bus.fire_idx == 3'd1) fire_cyc = c;
      tick();
    end
    chk("loop_consumer_fired", 64'(fire_cyc >= 0), 64'd1);
    chk("loop_wakeup_to_fire", 64'(fire_cyc - wake_cyc), 64'd1);

    // Full queue: no dispatch accepted, stalled offer stays put
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(0, 1, 'h00, 64'h200 + 64'(i), 0, 0);
      chk($sformatf("fill_disp_idx%0d", i), 64'(bus.disp_idx), 64'(i));
      tick();
    end
    drive(0, 1, 'h00, 64'hDEAD, 0, 0);
    chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    chk("full_occupancy", 64'(bus.occupancy), 64'd8);
    chk("full_fire_idx", 64'(bus.fire_idx), 64'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, '0, 0, 0);
      chk("full_occ_after_extra", 64'(bus.occupancy), 64'd8);
      chk("stall_fire_idx_stable", 64'(bus.fire_idx), 64'd0);
      chk("stall_fire_pkt", bus.fire_pkt, 64'h200);
      tick();
    end

    // Stalled offer stays put even when a lower-index entry wakes up
    do_reset();
    drive(0, 1, 'h80, 64'h300, 0, 0);
    tick();
    drive(0, 1, 'h00, 64'h301, 0, 0);
    tick();
    drive(0, 0, 0, '0, 0, 0);
    chk("hold_first_offer", 64'(bus.fire_idx), 64'd1);
    tick();
    drive(0, 0, 0, '0, 0, 'h80);
    chk("hold_during_wakeup", 64'(bus.fire_idx), 64'd1);
    tick();
    drive(0, 0, 0, '0, 1, 0);
    chk("hold_after_wakeup_idx", 64'(bus.fire_idx), 64'd1);
    chk("hold_after_wakeup_pkt", bus.fire_pkt, 64'h301);
    tick();
    drive(0, 0, 0, '0, 1, 0);
    chk("hold_next_idx", 64'(bus.fire_idx), 64'd0);
    chk("hold_next_pkt", bus.fire_pkt, 64'h300);
    tick();

    // Selection policy: idx2 older than re-used idx0, both ready together
    do_reset();
    drive(0, 1, 'h00, 64'h10, 0, 0);
    tick();
    drive(0, 1, 'h80, 64'h11, 0, 0);
    chk("age_e0_offered", 64'(bus.fire_idx), 64'd0);
    tick();
    drive(0, 1, 'h40, 64'h22, 1, 0);
    chk("age_disp_idx2", 64'(bus.disp_idx), 64'd2);
    tick();
    drive(0, 1, 'h40, 64'h33, 0, 0);
    chk("age_disp_idx0", 64'(bus.disp_idx), 64'd0);
    chk("age_none_ready", 64'(bus.fire_valid), 64'd0);
    tick();
    drive(0, 0, 0, '0, 0, 'h40);
    tick();
    drive(0, 0, 0, '0, 1, 0);
    chk("age_first_valid", 64'(bus.fire_valid), 64'd1);
    chk("age_first_idx", 64'(bus.fire_idx), 64'(AGE_FIRST));
    tick();
    drive(0, 0, 0, '0, 1, 0);
    chk("age_second_idx", 64'(bus.fire_idx), 64'(AGE_SECOND));
    chk("age_second_pkt", bus.fire_pkt, (AGE_SECOND == 2) ? 64'h22 : 64'h33);
    tick();

    // Flush with five valid entries and a pending offer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 'h00, 64'h400 + 64'(i), 0, 0);
      tick();
    end
    drive(1, 1, 'h00, 64'h4FF, 1, 0);
    chk("flush_fire_valid", 64'(bus.fire_valid), 64'd0);
    chk("flush_disp_ready", 64'(bus.disp_ready), 64'd0);
    chk("flush_fire_pkt", bus.fire_pkt, 64'h0);
    tick();
    drive(0, 0, 0, '0, 0, 0);
    chk("flush_occupancy", 64'(bus.occupancy), 64'd0);
    chk("flush_lrm", 64'(bus.local_ready_mask), 64'd0);
    chk("flush_fire_valid_after", 64'(bus.fire_valid), 64'd0);
    chk("flush_disp_ready_after", 64'(bus.disp_ready), 64'd1);
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      gm = int'($urandom & $urandom & $urandom) & ((1 << N) - 1);
      if ($urandom_range(0, 1) == 1) gm = gm | int'(bus.local_ready_mask);
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 3) != 0),
            int'($urandom & $urandom & $urandom) & ((1 << N) - 1),
            {$urandom, $urandom},
            ($urandom_range(0, 2) != 0),
            gm);
      check_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
